rs232_rx_dat: RTL
=================

// Module: rs232_rx_dat
// PURPOSE
//  Receive side of the RS232 link; mirror of the TX data path. Samples the async rx pin
//  and deframes 8N1 frames (start, 8 data bits LSB first, 1 stop).
//  Delivers each good byte with a 1-cycle valid strobe and flags framing errors.
//  Sits between the board rx pin and the command/loopback logic.
// PARAMETERS
//  CLK_FREQ   50_000_000  clk_ref frequency, Hz
//  BAUD       115200      line rate, bit/s
//  BAUD_DIV   CLK_FREQ/BAUD  clocks per bit (localparam); must be >= 4
//  HALF       BAUD_DIV/2  clocks to mid start bit (localparam, integer division)
// PORTS
//  clk_ref      in   1  system clock
//  rst_n        in   1  reset, asynchronous, active-low
//  i_rx_pin     in   1  async serial input, idle high
//  o_rx_dat     out  8  last received byte; held until next good frame
//  o_rx_vld     out  1  1-cycle strobe, o_rx_dat valid
//  o_frame_err  out  1  1-cycle strobe, stop bit sampled low
//  o_rx_busy    out  1  high from start detect until return to IDLE
//  o_ctrl_cnt   out  4  bit index: 0 start, 1..8 data, 9 stop; 0 in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; sync flops = 1; FSM = IDLE; baud counter = 0; shift reg = 0.
//  Input sync: 2-flop synchronizer, rx_s = 2nd stage. No other filtering.
//  Baud counter width $clog2(BAUD_DIV); cleared on every state entry; counts clk_ref.
//  T0 = first cycle rx_s==0 while in IDLE (prev rx_s==1). Counter restarts at T0.
//  FSM states:
//   IDLE : busy=0. Falling edge on rx_s -> START.
//   START: ctrl_cnt=0. At T0+HALF sample rx_s: 0 -> DATA; 1 -> IDLE (glitch, no strobe).
//   DATA : bit n (1..8) sampled at T0+HALF+n*BAUD_DIV, shifted in LSB first;
//          ctrl_cnt=n during bit n; after bit 8 -> STOP.
//   STOP : ctrl_cnt=9. Sample at T0+HALF+9*BAUD_DIV.
//          1 -> o_rx_dat<=shift, o_rx_vld=1 next cycle, -> IDLE.
//          0 -> o_frame_err=1 next cycle, o_rx_dat unchanged, -> BREAK.
//   BREAK: busy=1; wait until rx_s==1, then -> IDLE (no false start on held-low line).
//  Latency: o_rx_vld rises HALF+9*BAUD_DIV+1 cycles after T0 (+2 sync cycles from pin).
//  Back-to-back: IDLE re-entered mid stop bit; next falling edge accepted immediately.
//  o_rx_vld and o_frame_err never high together; each exactly 1 cycle per frame.
//  Reset mid-frame: abort, return to reset values; partial byte discarded.
//  Line held low at reset release: rx_s starts 1, so falling edge seen -> START ->
//   data/stop low -> frame_err, BREAK until high. Accepted behaviour.
// TESTING  (CLK_FREQ=1_000_000, BAUD=100_000 -> BAUD_DIV=10, HALF=5)
//  1 frame 0x55, stop=1 -> o_rx_vld 1 cycle, o_rx_dat=0x55, o_frame_err=0.
//  2 frames 0xA3 then 0x0F, no idle gap -> two vld strobes, data 0xA3, 0x0F in order.
//  3 pin low 3 cycles then high -> START then IDLE, no vld/err, busy drops by T0+6.
//  4 frame 0xFF with stop=0, line low 30 more cycles -> frame_err 1 cycle, no vld,
//    busy high until line high, o_rx_dat keeps prior value.
//  5 rst_n low during data bit 4, then frame 0x3C -> outputs 0 in reset;
//    next vld has o_rx_dat=0x3C.
//  6 loop TX->RX, all 256 values, BAUD_DIV +/-3% skew -> every byte matches, no frame_err.

Source files
------------

// File: rtl/rs232_rx_dat_if.sv
// Receiver-side signal bundle: serial pin in, deframed byte and status out.
// The slave modport is the receiver; the master modport is its driver/consumer.
interface rs232_rx_dat_if;
  logic       i_rx_pin;
  logic [7:0] o_rx_dat;
  logic       o_rx_vld;
  logic       o_frame_err;
  logic       o_rx_busy;
  logic [3:0] o_ctrl_cnt;

  modport master (
    output i_rx_pin,
    input  o_rx_dat, o_rx_vld, o_frame_err, o_rx_busy, o_ctrl_cnt
  );

  modport slave (
    input  i_rx_pin,
    output o_rx_dat, o_rx_vld, o_frame_err, o_rx_busy, o_ctrl_cnt
  );
endinterface

// File: rtl/rs232_rx_dat.sv
// 8N1 serial receiver: synchronizes the rx pin, samples each bit at mid-cell
// and delivers good bytes with a one-cycle strobe, flagging low stop bits.
module rs232_rx_dat #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic          clk_ref,
  input  logic          rst_n,
  rs232_rx_dat_if.slave bus
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state, next_state;
  logic            rx_meta, rx_s, rx_prev;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      rx_dat;
  logic            rx_vld, frame_err;
  logic            cnt_clr, take_bit, load, ferr;

  // Sync stages reset high so an idle line produces no edge after reset
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx_pin;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    take_bit   = 1'b0;
    load       = 1'b0;
    ferr       = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          next_state = S_START;
          cnt_clr    = 1'b1;
        end
      end
      S_START: begin
        if (baud_cnt == HALF_LAST) begin
          cnt_clr    = 1'b1;
          next_state = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          take_bit = 1'b1;
          if (bit_idx == 4'd8) next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            load       = 1'b1;
            next_state = S_IDLE;
          end else begin
            ferr       = 1'b1;
            next_state = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a stuck-low line cannot re-trigger
        if (rx_s) begin
          cnt_clr    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_idx   <= 4'd0;
      shift     <= 8'd0;
      rx_dat    <= 8'd0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cnt_clr || state == S_IDLE) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;

      if (state == S_START && next_state == S_DATA) bit_idx <= 4'd1;
      else if (take_bit)                            bit_idx <= bit_idx + 4'd1;
      else if (next_state != S_DATA && next_state != S_STOP) bit_idx <= 4'd0;

      // LSB arrives first, so shift right and insert at the top
      if (take_bit) shift <= {rx_s, shift[7:1]};
      if (load)     rx_dat <= shift;
      rx_vld    <= load;
      frame_err <= ferr;
    end
  end

  assign bus.o_rx_dat    = rx_dat;
  assign bus.o_rx_vld    = rx_vld;
  assign bus.o_frame_err = frame_err;
  assign bus.o_rx_busy   = (state != S_IDLE);
  assign bus.o_ctrl_cnt  = bit_idx;

endmodule
